// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - controller <-> datapath/memory signal bundle
interface mips_multicycle_ctrl_if;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write;
    logic        pc_write_cond;
    logic        ir_write;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        iord;
    logic        alu_src_a;
    logic        reg_dst;
    logic        mem_to_reg;
    logic [1:0]  alu_src_b;
    logic [1:0]  pc_src;
    logic [2:0]  alu_op;
    logic [3:0]  state;
    logic        instr_done;
    logic [15:0] retired;
    logic        illegal;
    logic        timeout;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write,
               iord, alu_src_a, reg_dst, mem_to_reg, alu_src_b, pc_src, alu_op,
               state, instr_done, retired, illegal, timeout
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write,
               iord, alu_src_a, reg_dst, mem_to_reg, alu_src_b, pc_src, alu_op,
               state, instr_done, retired, illegal, timeout
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM with memory wait timeout
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    mips_multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12,
        S_BAD       = 4'd13
    } state_t;

    typedef struct packed {
        logic       jump_pc;
        logic       pc_write_cond;
        logic       fetch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       iord;
        logic       alu_src_a;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
        logic       done;
    } ctrl_t;

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT);

    state_t         r_state;
    ctrl_t          r_ctl;
    logic [WW-1:0]  r_wait;
    logic [15:0]    r_retired;
    logic           r_illegal;
    logic           r_timeout;

    state_t         w_next;
    logic           w_wait_state;
    logic           w_timeout;
    logic           w_done;

    // Static per-state decode; the mem_ready-qualified strobes are gated afterwards.
    function automatic ctrl_t f_ctl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:     begin c.fetch = 1'b1; c.mem_read = 1'b1; c.alu_src_b = 2'd1; end
            S_DECODE:    c.alu_src_b = 2'd3;
            S_MEM_ADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
            S_MEM_READ:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
            S_MEM_WB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.done = 1'b1; end
            S_MEM_WRITE: begin c.mem_write = 1'b1; c.iord = 1'b1; end
            S_R_EXEC:    begin c.alu_src_a = 1'b1; c.alu_op = 3'd2; end
            S_R_WB:      begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.done = 1'b1; end
            S_BRANCH:    begin
                c.alu_src_a = 1'b1; c.alu_op = 3'd1; c.pc_write_cond = 1'b1;
                c.pc_src = 2'd1; c.done = 1'b1;
            end
            S_JUMP:      begin c.jump_pc = 1'b1; c.pc_src = 2'd2; c.done = 1'b1; end
            S_ADDI_EXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
            S_ADDI_WB:   begin c.reg_write = 1'b1; c.done = 1'b1; end
            default:     c = '0;
        endcase
        return c;
    endfunction

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                          (r_state == S_MEM_WRITE);
    // A ready in the last allowed wait cycle still wins over the timeout.
    assign w_timeout = w_wait_state && !bus.mem_ready && (r_wait == WAIT_MAX);
    assign w_done    = r_ctl.done || ((r_state == S_MEM_WRITE) && bus.mem_ready);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      w_next = S_FETCH;
            S_FETCH:     w_next = bus.mem_ready ? S_DECODE : (w_timeout ? S_IDLE : S_FETCH);
            S_DECODE: begin
                case (bus.opcode)
                    6'h00:        w_next = S_R_EXEC;
                    6'h23, 6'h2B: w_next = S_MEM_ADDR;
                    6'h04:        w_next = S_BRANCH;
                    6'h02:        w_next = S_JUMP;
                    6'h08:        w_next = S_ADDI_EXEC;
                    default:      w_next = S_BAD;
                endcase
            end
            S_MEM_ADDR:  w_next = (bus.opcode == 6'h23) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  w_next = bus.mem_ready ? S_MEM_WB : (w_timeout ? S_IDLE : S_MEM_READ);
            S_MEM_WRITE: w_next = bus.mem_ready ? S_FETCH : (w_timeout ? S_IDLE : S_MEM_WRITE);
            S_R_EXEC:    w_next = S_R_WB;
            S_ADDI_EXEC: w_next = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB, S_BAD: w_next = S_FETCH;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ctl     <= '0;
            r_wait    <= '0;
            r_retired <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ctl   <= f_ctl(w_next);
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if (w_wait_state) begin
                r_wait <= r_wait + 1'b1;
            end
            if (w_done) begin
                r_retired <= r_retired + 16'd1;
            end
            if (w_next == S_BAD) begin
                r_illegal <= 1'b1;
            end
            if (w_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign bus.ir_write      = r_ctl.fetch && bus.mem_ready;
    assign bus.pc_write      = r_ctl.jump_pc || (r_ctl.fetch && bus.mem_ready);
    assign bus.pc_write_cond = r_ctl.pc_write_cond;
    assign bus.mem_read      = r_ctl.mem_read;
    assign bus.mem_write     = r_ctl.mem_write;
    assign bus.reg_write     = r_ctl.reg_write;
    assign bus.iord          = r_ctl.iord;
    assign bus.alu_src_a     = r_ctl.alu_src_a;
    assign bus.reg_dst       = r_ctl.reg_dst;
    assign bus.mem_to_reg    = r_ctl.mem_to_reg;
    assign bus.alu_src_b     = r_ctl.alu_src_b;
    assign bus.pc_src        = r_ctl.pc_src;
    assign bus.alu_op        = r_ctl.alu_op;
    assign bus.state         = r_state;
    assign bus.instr_done    = w_done;
    assign bus.retired       = r_retired;
    assign bus.illegal       = r_illegal;
    assign bus.timeout       = r_timeout;

endmodule
